// File: rtl/bsg_dff_gatestack_strobe_gen.sv
// Drives a per-bit-clocked gate-stack bank: presents a data word, then walks
// one glitch-free strobe pulse per set mask bit, lowest bit first.
module bsg_dff_gatestack_strobe_gen #(
    parameter int width_p        = 16,
    parameter int setup_cycles_p = 1,
    parameter int high_cycles_p  = 2,
    parameter int low_cycles_p   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] mask_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic [width_p-1:0] strobe_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int cnt_max_lp =
        (setup_cycles_p > high_cycles_p)
            ? ((setup_cycles_p > low_cycles_p) ? setup_cycles_p : low_cycles_p)
            : ((high_cycles_p  > low_cycles_p) ? high_cycles_p  : low_cycles_p);
    localparam int cnt_w_lp = (cnt_max_lp > 1) ? $clog2(cnt_max_lp) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_e;

    state_e              state_reg, state_next;
    logic [cnt_w_lp-1:0] cnt_reg, cnt_next;
    logic [width_p-1:0]  rem_reg, rem_next;
    logic [width_p-1:0]  data_reg, data_next;
    logic [width_p-1:0]  strobe_reg, strobe_next;
    logic                done_reg, done_next;
    logic [width_p-1:0]  low_onehot;
    logic                accept;

    assign ready_o    = ~reset_i & (state_reg == IDLE);
    assign accept     = v_i & ready_o;
    // Isolate the lowest set bit of the remaining mask.
    assign low_onehot = rem_reg & (~rem_reg + width_p'(1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            data_reg   <= '0;
            strobe_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            data_reg   <= data_next;
            strobe_reg <= strobe_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    data_next = data_i;
                    rem_next  = mask_i;
                    cnt_next  = cnt_w_lp'(setup_cycles_p - 1);
                    state_next = (mask_i == '0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = HIGH;
                    cnt_next   = cnt_w_lp'(high_cycles_p - 1);
                end else begin
                    cnt_next = cnt_reg - cnt_w_lp'(1);
                end
            end
            HIGH: begin
                if (cnt_reg == '0) begin
                    rem_next   = rem_reg & ~low_onehot;
                    state_next = LOW;
                    cnt_next   = cnt_w_lp'(low_cycles_p - 1);
                end else begin
                    cnt_next = cnt_reg - cnt_w_lp'(1);
                end
            end
            LOW: begin
                if (cnt_reg == '0) begin
                    if (rem_reg != '0) begin
                        state_next = HIGH;
                        cnt_next   = cnt_w_lp'(high_cycles_p - 1);
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt_reg - cnt_w_lp'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so they leave straight from flops;
    // rem is stable throughout HIGH, so low_onehot names the same bit there.
    always_comb begin
        strobe_next = '0;
        done_next   = (state_next == DONE);
        if (state_next == HIGH)
            strobe_next = low_onehot;
    end

    assign data_o   = data_reg;
    assign strobe_o = strobe_reg;
    assign done_o   = done_reg;
    assign busy_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_bsg_dff_gatestack_strobe_gen.sv
// Directed bench for the gate-stack strobe generator, with a behavioural
// gate-stack model capturing data_o on each strobe rising edge.
module tb_bsg_dff_gatestack_strobe_gen;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i, v2;
    logic [15:0] data_i, mask_i, d2, m2;
    logic        ready_o, busy_o, done_o;
    logic [15:0] data_o, strobe_o;
    logic        ready2, busy2, done2;
    logic [15:0] data2, strobe2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] gs;
    logic [15:0] strobe_prev = '0;

    always #5 clk = ~clk;

    bsg_dff_gatestack_strobe_gen dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .mask_i(mask_i),
        .ready_o(ready_o), .data_o(data_o), .strobe_o(strobe_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    bsg_dff_gatestack_strobe_gen #(
        .width_p(16), .setup_cycles_p(3), .high_cycles_p(1), .low_cycles_p(2)
    ) dut2 (
        .clk_i(clk), .reset_i(reset_i), .v_i(v2), .data_i(d2), .mask_i(m2),
        .ready_o(ready2), .data_o(data2), .strobe_o(strobe2),
        .busy_o(busy2), .done_o(done2)
    );

    // Gate-stack model: bit k latches data_o[k] on a rising strobe_o[k].
    always @(strobe_o) begin
        for (int k = 0; k < 16; k++)
            if (strobe_o[k] === 1'b1 && strobe_prev[k] !== 1'b1)
                gs[k] = data_o[k];
        strobe_prev = strobe_o;
    end

    always @(negedge clk) begin
        n_cmp++;
        if (!$onehot0(strobe_o)) begin
            n_fail++;
            $display("FAIL onehot0 strobe_o=%h required one-hot or zero", strobe_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b1; data_i = 16'hDEAD; mask_i = 16'h0001;
        v2 = 1'b0; d2 = '0; m2 = '0;
        tick(); tick();
        n_cmp++;
        if ({ready_o, busy_o, done_o, data_o, strobe_o} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state rdy=%b busy=%b done=%b data=%h strobe=%h required all 0",
                     ready_o, busy_o, done_o, data_o, strobe_o);
        end
        v_i = 1'b0;
        reset_i = 1'b0;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1 || data_o !== 16'h0000 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release rdy=%b data=%h busy=%b required 1/0000/0",
                     ready_o, data_o, busy_o);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] exp_s [1:9] = '{16'h0, 16'h1, 16'h1, 16'h0, 16'h4, 16'h4, 16'h0, 16'h0, 16'h0};
        logic        exp_d [1:9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_ready0 got %b required 1", ready_o);
        end
        v_i = 1'b1; data_i = 16'hA5A5; mask_i = 16'h0005;
        for (int c = 1; c <= 9; c++) begin
            tick();
            v_i = 1'b0;
            n_cmp++;
            if (strobe_o !== exp_s[c] || done_o !== exp_d[c]) begin
                n_fail++;
                $display("FAIL basic_c%0d strobe=%h done=%b required %h/%b",
                         c, strobe_o, done_o, exp_s[c], exp_d[c]);
            end
            if (c == 1) begin
                n_cmp++;
                if (data_o !== 16'hA5A5 || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_data data=%h busy=%b required a5a5/1", data_o, busy_o);
                end
            end
        end
        n_cmp++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_ready9 rdy=%b busy=%b required 1/0", ready_o, busy_o);
        end
        n_cmp++;
        if ((gs & 16'h0005) !== 16'h0005) begin
            n_fail++; $display("FAIL basic_gatestack got %h required 0005", gs & 16'h0005);
        end
    endtask

    task automatic test_zero_mask();
        v_i = 1'b1; data_i = 16'h5A5A; mask_i = 16'h0000;
        tick();
        v_i = 1'b0;
        n_cmp++;
        if (done_o !== 1'b1 || data_o !== 16'h5A5A || strobe_o !== 16'h0) begin
            n_fail++;
            $display("FAIL zero_c1 done=%b data=%h strobe=%h required 1/5a5a/0000",
                     done_o, data_o, strobe_o);
        end
        tick();
        n_cmp++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || strobe_o !== 16'h0) begin
            n_fail++;
            $display("FAIL zero_c2 rdy=%b done=%b strobe=%h required 1/0/0000",
                     ready_o, done_o, strobe_o);
        end
    endtask

    task automatic test_full_walk();
        logic [15:0] exp_s;
        int idx;
        v_i = 1'b1; data_i = 16'h1234; mask_i = 16'hFFFF;
        for (int c = 1; c <= 50; c++) begin
            tick();
            v_i = 1'b0;
            exp_s = '0;
            if (c >= 2) begin
                idx = c - 2;
                if (idx / 3 < 16 && idx % 3 < 2)
                    exp_s = 16'h0001 << (idx / 3);
            end
            n_cmp++;
            if (strobe_o !== exp_s || done_o !== (c == 50)) begin
                n_fail++;
                $display("FAIL walk_c%0d strobe=%h done=%b required %h/%b",
                         c, strobe_o, done_o, exp_s, (c == 50));
            end
        end
        tick();
        n_cmp++;
        if (gs !== 16'h1234 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL walk_gatestack gs=%h rdy=%b required 1234/1", gs, ready_o);
        end
    endtask

    task automatic test_back_to_back();
        v_i = 1'b1; data_i = 16'h1111; mask_i = 16'h0001;
        tick();
        data_i = 16'hBEEF; mask_i = 16'h0002;
        for (int c = 1; c <= 5; c++) begin
            n_cmp++;
            if (ready_o !== 1'b0 || data_o !== 16'h1111 || done_o !== (c == 5)) begin
                n_fail++;
                $display("FAIL bp_c%0d rdy=%b data=%h done=%b required 0/1111/%b",
                         c, ready_o, data_o, done_o, (c == 5));
            end
            tick();
        end
        n_cmp++;
        if (ready_o !== 1'b1 || data_o !== 16'h1111) begin
            n_fail++;
            $display("FAIL bp_c6 rdy=%b data=%h required 1/1111", ready_o, data_o);
        end
        tick();
        v_i = 1'b0;
        n_cmp++;
        if (data_o !== 16'hBEEF || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_c7 data=%h busy=%b required beef/1", data_o, busy_o);
        end
        tick();
        n_cmp++;
        if (strobe_o !== 16'h0002) begin
            n_fail++; $display("FAIL bp_c8 strobe=%h required 0002", strobe_o);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_c11 done=%b required 1", done_o);
        end
        tick();
    endtask

    task automatic test_async_reset();
        v_i = 1'b1; data_i = 16'hFFFF; mask_i = 16'h0004;
        tick();
        v_i = 1'b0;
        tick();
        n_cmp++;
        if (strobe_o !== 16'h0004) begin
            n_fail++; $display("FAIL ar_high strobe=%h required 0004", strobe_o);
        end
        #2 reset_i = 1'b1;
        #1;
        n_cmp++;
        if (strobe_o !== 16'h0 || busy_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_drop strobe=%h busy=%b done=%b rdy=%b required 0000/0/0/0",
                     strobe_o, busy_o, done_o, ready_o);
        end
        tick();
        reset_i = 1'b0;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL ar_release rdy=%b done=%b required 1/0", ready_o, done_o);
        end
        v_i = 1'b1; data_i = 16'h0F0F; mask_i = 16'h0100;
        tick();
        v_i = 1'b0;
        tick();
        n_cmp++;
        if (strobe_o !== 16'h0100) begin
            n_fail++; $display("FAIL ar_rerun_strobe strobe=%h required 0100", strobe_o);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_fail++; $display("FAIL ar_rerun_done done=%b required 1", done_o);
        end
        tick();
    endtask

    task automatic test_param_sweep();
        logic [15:0] exp_s [1:11] = '{16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0,
                                      16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
        v2 = 1'b1; d2 = 16'hC3C3; m2 = 16'h8001;
        for (int c = 1; c <= 11; c++) begin
            tick();
            v2 = 1'b0;
            n_cmp++;
            if (strobe2 !== exp_s[c] || done2 !== (c == 10)) begin
                n_fail++;
                $display("FAIL sweep_c%0d strobe=%h done=%b required %h/%b",
                         c, strobe2, done2, exp_s[c], (c == 10));
            end
        end
        n_cmp++;
        if (ready2 !== 1'b1 || data2 !== 16'hC3C3 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_end rdy=%b data=%h busy=%b required 1/c3c3/0",
                     ready2, data2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_mask();
        test_full_walk();
        test_back_to_back();
        test_async_reset();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
